// File: rtl/qos_aging_rr_arbiter_if.sv
// Request/grant bundle between the per-core request ports and the QoS arbiter.
//  req_valid_i  per-requester beat valid
//  req_level_i  2-bit QoS level per requester, bits [2i+1:2i]
//  req_last_i   last beat of requester i's current transaction
//  req_ready_o  beat accepted from requester i
//  grant_o      one-hot owner (zero when idle), grant_valid_o = |grant_o
//  grant_idx_o  owner index, grant_level_o owner level captured at grant
//  boosted_o    current grant was won through aging
// slave  : arbiter side
// master : requester side
interface qos_aging_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid_i;
  logic [2*NUM_REQ-1:0] req_level_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [NUM_REQ-1:0]   grant_o;
  logic                 grant_valid_o;
  logic [IDX_W-1:0]     grant_idx_o;
  logic [1:0]           grant_level_o;
  logic                 boosted_o;

  modport slave (
    input  req_valid_i, req_level_i, req_last_i,
    output req_ready_o, grant_o, grant_valid_o, grant_idx_o, grant_level_o, boosted_o
  );

  modport master (
    output req_valid_i, req_level_i, req_last_i,
    input  req_ready_o, grant_o, grant_valid_o, grant_idx_o, grant_level_o, boosted_o
  );
endinterface

// File: rtl/qos_aging_rr_arbiter.sv
// QoS arbiter with round-robin tie break and anti-starvation aging.
// Picks the highest effective priority among valid requesters (aged requesters
// outrank CRITICAL), breaks ties round-robin from rr_ptr, then holds the grant
// until the owner's last beat transfers.
// Ports:
//  clk_i  clock
//  rst_ni async active-low reset
//  bus    request/grant bundle (slave side)

// Per-requester saturating wait counter.
module qos_age_cnt #(
  parameter int AGE_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr,   // won arbitration this cycle
  input  logic             inc,   // waiting (valid and not the active owner)
  output logic [AGE_W-1:0] age
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             age <= '0;
    else if (clr)            age <= '0;
    else if (inc) begin
      if (age != '1)         age <= age + 1'b1;
    end
    else                     age <= '0;
  end
endmodule

module qos_aging_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int AGE_W      = 4,
  parameter int AGE_THRESH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  qos_aging_rr_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [1:0]           level_q, level_d;
  logic                 boost_q, boost_d;
  logic [IDX_W-1:0]     rr_q, rr_d;

  logic [NUM_REQ-1:0][AGE_W-1:0] age;
  logic [NUM_REQ-1:0][2:0]       eff;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [2:0]       win_eff;
  logic             last_xfer;

  // Effective priority: 4 once aged past the threshold, else the QoS level.
  // Age counters, one instance per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic clr, inc;
    assign eff[i] = (age[i] >= AGE_W'(AGE_THRESH)) ? 3'd4
                                                  : {1'b0, bus.req_level_i[2*i +: 2]};
    assign clr = (state_q == IDLE) && win_found && (win_idx == IDX_W'(i));
    assign inc = bus.req_valid_i[i] && !((state_q == BUSY) && (idx_q == IDX_W'(i)));
    qos_age_cnt #(.AGE_W(AGE_W)) u_age (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr    (clr),
      .inc    (inc),
      .age    (age[i])
    );
  end

  // Scan from rr_ptr upward with wrap; strict '>' keeps the first index found
  // on ties, which is what gives round-robin fairness within a level.
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    win_eff   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (bus.req_valid_i[j] && (!win_found || eff[j] > win_eff)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
        win_eff   = eff[j];
      end
    end
  end

  assign last_xfer = (state_q == BUSY) && bus.req_valid_i[idx_q] && bus.req_last_i[idx_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    level_d = level_q;
    boost_d = boost_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          grant_d = NUM_REQ'(1) << win_idx;
          idx_d   = win_idx;
          level_d = bus.req_level_i[2*win_idx +: 2];
          boost_d = (win_eff == 3'd4);
        end
      end
      BUSY: begin
        // Owner dropping valid just stalls; only the last beat releases.
        if (last_xfer) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          level_d = '0;
          boost_d = 1'b0;
          rr_d    = (int'(idx_q) == NUM_REQ-1) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      level_q <= '0;
      boost_q <= 1'b0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      level_q <= level_d;
      boost_q <= boost_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.req_ready_o   = (state_q == BUSY) ? (bus.req_valid_i & grant_q) : '0;
  assign bus.grant_o       = grant_q;
  assign bus.grant_valid_o = |grant_q;
  assign bus.grant_idx_o   = idx_q;
  assign bus.grant_level_o = level_q;
  assign bus.boosted_o     = boost_q;
endmodule

// File: tb/tb_qos_aging_rr_arbiter.sv
module tb_qos_aging_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  qos_aging_rr_arbiter_if #(.NUM_REQ(4)) bus ();

  qos_aging_rr_arbiter #(.NUM_REQ(4), .AGE_W(4), .AGE_THRESH(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid_i = '0;
    bus.req_level_i = '0;
    bus.req_last_i  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid_i = 4'hF;
    bus.req_level_i = '0;
    bus.req_last_i  = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", bus.grant_o); end
    checks++; if (bus.grant_valid_o !== 1'b0) begin errors++; $display("FAIL reset_gvalid got %b exp 0", bus.grant_valid_o); end
    checks++; if (bus.grant_idx_o !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", bus.grant_idx_o); end
    checks++; if (bus.grant_level_o !== 2'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.grant_level_o); end
    checks++; if (bus.boosted_o !== 1'b0) begin errors++; $display("FAIL reset_boost got %b exp 0", bus.boosted_o); end
    checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready_o); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL release_nogrant got %b exp 0000", bus.grant_o); end
    @(posedge clk); #1;
    checks++; if (bus.grant_o !== 4'b0001) begin errors++; $display("FAIL release_grant got %b exp 0001", bus.grant_o); end
    checks++; if (bus.grant_valid_o !== 1'b1) begin errors++; $display("FAIL release_gvalid got %b exp 1", bus.grant_valid_o); end
  endtask

  task automatic test_priority();
    do_reset();
    bus.req_valid_i = 4'b0101;
    bus.req_level_i = 8'b00_11_00_00;
    #1;
    checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL idle_ready got %b exp 0000", bus.req_ready_o); end
    @(posedge clk); #1;
    checks++; if (bus.grant_o !== 4'b0100) begin errors++; $display("FAIL prio_grant got %b exp 0100", bus.grant_o); end
    checks++; if (bus.grant_idx_o !== 2'd2) begin errors++; $display("FAIL prio_idx got %0d exp 2", bus.grant_idx_o); end
    checks++; if (bus.grant_level_o !== 2'd3) begin errors++; $display("FAIL prio_level got %0d exp 3", bus.grant_level_o); end
    checks++; if (bus.boosted_o !== 1'b0) begin errors++; $display("FAIL prio_boost got %b exp 0", bus.boosted_o); end
    checks++; if (bus.req_ready_o !== 4'b0100) begin errors++; $display("FAIL prio_ready got %b exp 0100", bus.req_ready_o); end
  endtask

  task automatic test_rr();
    logic [3:0] exp_g [5];
    exp_g = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};
    do_reset();
    bus.req_valid_i = 4'b1010;
    bus.req_level_i = 8'b10_00_10_00;
    bus.req_last_i  = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      checks++; if (bus.grant_o !== exp_g[t]) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", t, bus.grant_o, exp_g[t]); end
      @(posedge clk); #1;
      checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL rr_gap%0d got %b exp 0000", t, bus.grant_o); end
    end
  endtask

  task automatic test_aging();
    int beats1;
    beats1 = 0;
    do_reset();
    bus.req_valid_i = 4'b0011;
    bus.req_level_i = 8'b00_00_11_00;
    bus.req_last_i  = 4'b0001;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1 || cyc == 4 || cyc == 7) begin
        checks++; if (bus.grant_o !== 4'b0010 || bus.boosted_o !== 1'b0) begin
          errors++; $display("FAIL age_req1_c%0d got %b/%b exp 0010/0", cyc, bus.grant_o, bus.boosted_o); end
      end
      if (cyc == 9) begin
        checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL age_gap got %b exp 0000", bus.grant_o); end
      end
      if (cyc == 10) begin
        checks++; if (bus.grant_o !== 4'b0001) begin errors++; $display("FAIL age_boost_grant got %b exp 0001", bus.grant_o); end
        checks++; if (bus.boosted_o !== 1'b1) begin errors++; $display("FAIL age_boost_flag got %b exp 1", bus.boosted_o); end
        checks++; if (bus.grant_level_o !== 2'd0) begin errors++; $display("FAIL age_boost_level got %0d exp 0", bus.grant_level_o); end
      end
      if (cyc == 12) begin
        checks++; if (bus.grant_o !== 4'b0010 || bus.boosted_o !== 1'b0) begin
          errors++; $display("FAIL age_after got %b/%b exp 0010/0", bus.grant_o, bus.boosted_o); end
      end
      bus.req_last_i[1] = (beats1 == 1);
      #1;
      if (bus.req_ready_o[1]) beats1 = (beats1 == 1) ? 0 : 1;
    end
  endtask

  task automatic test_hold();
    logic [3:0] exp_r;
    do_reset();
    bus.req_valid_i = 4'b0100;
    bus.req_level_i = 8'b00_01_00_00;
    bus.req_last_i  = 4'b0000;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clk); #1;
      if (cyc <= 8) begin
        checks++; if (bus.grant_o !== 4'b0100) begin errors++; $display("FAIL hold_grant_c%0d got %b exp 0100", cyc, bus.grant_o); end
        checks++; if (bus.grant_level_o !== 2'd1) begin errors++; $display("FAIL hold_level_c%0d got %0d exp 1", cyc, bus.grant_level_o); end
      end else begin
        checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL hold_release got %b exp 0000", bus.grant_o); end
      end
      bus.req_valid_i[2] = (cyc == 1) || (cyc >= 7);
      bus.req_last_i[2]  = (cyc == 8);
      bus.req_valid_i[1] = 1'b1;
      bus.req_level_i[3:2] = 2'd3;
      if (cyc == 3) bus.req_level_i[5:4] = 2'd3;
      #1;
      exp_r = (cyc <= 8 && bus.req_valid_i[2]) ? 4'b0100 : 4'b0000;
      checks++; if (bus.req_ready_o !== exp_r) begin errors++; $display("FAIL hold_ready_c%0d got %b exp %b", cyc, bus.req_ready_o, exp_r); end
    end
    @(posedge clk); #1;
    checks++; if (bus.grant_o !== 4'b0010) begin errors++; $display("FAIL hold_next_grant got %b exp 0010", bus.grant_o); end
    checks++; if (bus.boosted_o !== 1'b1) begin errors++; $display("FAIL hold_next_boost got %b exp 1", bus.boosted_o); end
    checks++; if (bus.grant_level_o !== 2'd3) begin errors++; $display("FAIL hold_next_level got %0d exp 3", bus.grant_level_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req_valid_i = 4'b0001;
    bus.req_level_i = 8'b00_00_00_01;
    bus.req_last_i  = 4'b0000;
    @(posedge clk); #1;
    checks++; if (bus.grant_o !== 4'b0001 || bus.grant_level_o !== 2'd1) begin
      errors++; $display("FAIL ar_grant got %b/%0d exp 0001/1", bus.grant_o, bus.grant_level_o); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.grant_o !== 4'b0000) begin errors++; $display("FAIL ar_grant0 got %b exp 0000", bus.grant_o); end
    checks++; if (bus.grant_valid_o !== 1'b0) begin errors++; $display("FAIL ar_gvalid got %b exp 0", bus.grant_valid_o); end
    checks++; if (bus.grant_level_o !== 2'd0) begin errors++; $display("FAIL ar_level got %0d exp 0", bus.grant_level_o); end
    checks++; if (bus.req_ready_o !== 4'b0000) begin errors++; $display("FAIL ar_ready got %b exp 0000", bus.req_ready_o); end
    bus.req_valid_i = 4'b1000;
    bus.req_level_i = 8'b00_00_00_00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.grant_o !== 4'b1000 || bus.boosted_o !== 1'b0) begin
      errors++; $display("FAIL ar_regrant got %b/%b exp 1000/0", bus.grant_o, bus.boosted_o); end
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.req_level_i = '0;
    bus.req_last_i  = '0;
    test_reset();
    test_priority();
    test_rr();
    test_aging();
    test_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
